// File: rtl/spd_ramp.sv
// spd_ramp: slew-rate limiter feeding the motor driver speed inputs.
// Clamps signed left/right targets to +/-SPD_MAX and walks the driven speeds
// toward them by at most STEP every TICK_DIV clocks. Provides soft-start,
// controlled ramp-down to zero when ramp_en drops, and an immediate brake.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   lft_tgt, rght_tgt   signed 11-bit speed targets
//   ramp_en             1 = track targets, 0 = ramp both speeds to zero
//   brake               1 = zero both speeds on the next edge (dominant)
//   lft_spd, rght_spd   registered signed ramped speeds
//   at_tgt              registered; both speeds equal clamped targets in RAMP
module spd_ramp #(
    parameter int unsigned TICK_DIV = 1024,
    parameter logic [10:0] STEP     = 11'd8,
    parameter logic [10:0] SPD_MAX  = 11'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] lft_tgt,
    input  logic [10:0] rght_tgt,
    input  logic        ramp_en,
    input  logic        brake,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd,
    output logic        at_tgt
);

    localparam int unsigned SPD_W = 11;
    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SPD_W-1:0] lft_spd_q, lft_spd_d;
    logic [SPD_W-1:0] rght_spd_q, rght_spd_d;
    logic             at_tgt_q, at_tgt_d;

    logic [SPD_W-1:0] lft_tgt_c, rght_tgt_c;
    logic             tick_c;

    // Saturate a signed target to +/-SPD_MAX; 12-bit compare avoids edge overflow.
    function automatic logic [10:0] clamp_tgt(input logic [10:0] t);
        logic signed [11:0] t_s;
        logic signed [11:0] max_s;
        t_s   = signed'({t[10], t});
        max_s = signed'({1'b0, SPD_MAX});
        if (t_s > max_s)       return SPD_MAX;
        else if (t_s < -max_s) return 11'(-max_s);
        else                   return t;
    endfunction

    // One slew step toward tgt; lands exactly on tgt when within STEP.
    function automatic logic [10:0] step_to(input logic [10:0] spd, input logic [10:0] tgt);
        logic signed [11:0] diff;
        logic signed [11:0] mag;
        logic signed [11:0] step_s;
        diff   = signed'({tgt[10], tgt}) - signed'({spd[10], spd});
        mag    = diff[11] ? -diff : diff;
        step_s = signed'({1'b0, STEP});
        if (mag <= step_s) return tgt;
        else if (!diff[11]) return spd + STEP;
        else                return spd - STEP;
    endfunction

    assign lft_tgt_c  = clamp_tgt(lft_tgt);
    assign rght_tgt_c = clamp_tgt(rght_tgt);
    assign tick_c     = (cnt_q == CNT_LAST);

    // Next-state, tick counter and speed update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lft_spd_d  = lft_spd_q;
        rght_spd_d = rght_spd_q;
        at_tgt_d   = 1'b0;

        if (brake) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            lft_spd_d  = '0;
            rght_spd_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d      = '0;
                    lft_spd_d  = '0;
                    rght_spd_d = '0;
                    if (ramp_en) state_d = ST_RAMP;
                end
                ST_RAMP: begin
                    at_tgt_d = (lft_spd_q == lft_tgt_c) && (rght_spd_q == rght_tgt_c);
                    if (!ramp_en) begin
                        // Speeds are held on the entry edge; ramp-down starts at the next tick.
                        state_d = ST_STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
                        if (tick_c) begin
                            lft_spd_d  = step_to(lft_spd_q, lft_tgt_c);
                            rght_spd_d = step_to(rght_spd_q, rght_tgt_c);
                        end
                    end
                end
                ST_STOP: begin
                    if (ramp_en) begin
                        state_d = ST_RAMP;
                        cnt_d   = '0;
                    end else if (lft_spd_q == '0 && rght_spd_q == '0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
                        if (tick_c) begin
                            lft_spd_d  = step_to(lft_spd_q, '0);
                            rght_spd_d = step_to(rght_spd_q, '0);
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    lft_spd_d  = '0;
                    rght_spd_d = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lft_spd_q  <= '0;
            rght_spd_q <= '0;
            at_tgt_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lft_spd_q  <= lft_spd_d;
            rght_spd_q <= rght_spd_d;
            at_tgt_q   <= at_tgt_d;
        end
    end

    assign lft_spd  = lft_spd_q;
    assign rght_spd = rght_spd_q;
    assign at_tgt   = at_tgt_q;

endmodule

// File: tb/tb_spd_ramp.sv
// Testbench for spd_ramp: scenario tasks compared against an integer
// reference model of the slew limiter (TICK_DIV=4, STEP=8, SPD_MAX=1000).
module tb_spd_ramp;

    localparam int TICK_DIV = 4;
    localparam int STEP     = 8;
    localparam int SPD_MAX  = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] lft_tgt = '0;
    logic [10:0] rght_tgt = '0;
    logic        ramp_en = 1'b0;
    logic        brake = 1'b0;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        at_tgt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 = idle, 1 = tracking, 2 = ramping down.
    int m_mode = 0;
    int m_clk  = 0;   // clocks elapsed since the current mode was entered, mod TICK_DIV
    int m_l    = 0;
    int m_r    = 0;
    bit m_at   = 1'b0;

    spd_ramp #(
        .TICK_DIV(TICK_DIV),
        .STEP    (11'(STEP)),
        .SPD_MAX (11'(SPD_MAX))
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lft_tgt (lft_tgt),
        .rght_tgt(rght_tgt),
        .ramp_en (ramp_en),
        .brake   (brake),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
        .at_tgt  (at_tgt)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input logic [10:0] t);
        int v;
        v = int'($signed(t));
        if (v > SPD_MAX) return SPD_MAX;
        if (v < -SPD_MAX) return -SPD_MAX;
        return v;
    endfunction

    function automatic int approach(input int cur, input int tgt);
        if (tgt - cur > STEP) return cur + STEP;
        if (tgt - cur < -STEP) return cur - STEP;
        return tgt;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_clk = 0; m_l = 0; m_r = 0; m_at = 1'b0;
    endtask

    // Advance model and DUT by one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        int nl, nr, nmode, nclk;
        bit nat, tk;
        nl = m_l; nr = m_r; nmode = m_mode; nclk = m_clk; nat = 1'b0;
        tk = (m_clk == TICK_DIV - 1);
        if (brake) begin
            nmode = 0; nclk = 0; nl = 0; nr = 0;
        end else if (m_mode == 0) begin
            nl = 0; nr = 0; nclk = 0;
            if (ramp_en) nmode = 1;
        end else if (m_mode == 1) begin
            nat = (m_l == clampi(lft_tgt)) && (m_r == clampi(rght_tgt));
            if (!ramp_en) begin
                nmode = 2; nclk = 0;
            end else begin
                nclk = (m_clk + 1) % TICK_DIV;
                if (tk) begin
                    nl = approach(m_l, clampi(lft_tgt));
                    nr = approach(m_r, clampi(rght_tgt));
                end
            end
        end else begin
            if (ramp_en) begin
                nmode = 1; nclk = 0;
            end else if (m_l == 0 && m_r == 0) begin
                nmode = 0; nclk = 0;
            end else begin
                nclk = (m_clk + 1) % TICK_DIV;
                if (tk) begin
                    nl = approach(m_l, 0);
                    nr = approach(m_r, 0);
                end
            end
        end
        @(posedge clk);
        #1;
        m_l = nl; m_r = nr; m_mode = nmode; m_clk = nclk; m_at = nat;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({lft_spd, rght_spd, at_tgt} !== 23'd0) begin
            n_err++;
            $display("FAIL reset: got l=%0d r=%0d at=%0b, want 0 0 0",
                     $signed(lft_spd), $signed(rght_spd), at_tgt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_ramp_basic();
        lft_tgt = 11'(40); rght_tgt = 11'(-20); ramp_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            n_vec++;
            if ({lft_spd, rght_spd, at_tgt} !== {11'(m_l), 11'(m_r), m_at}) begin
                n_err++;
                $display("FAIL ramp_basic cyc%0d: got l=%0d r=%0d at=%0b, want l=%0d r=%0d at=%0b",
                         i, $signed(lft_spd), $signed(rght_spd), at_tgt, m_l, m_r, m_at);
            end
        end
    endtask

    task automatic test_stop();
        ramp_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            n_vec++;
            if ({lft_spd, rght_spd, at_tgt} !== {11'(m_l), 11'(m_r), m_at}) begin
                n_err++;
                $display("FAIL stop cyc%0d: got l=%0d r=%0d at=%0b, want l=%0d r=%0d at=%0b",
                         i, $signed(lft_spd), $signed(rght_spd), at_tgt, m_l, m_r, m_at);
            end
        end
        n_vec++;
        if ({lft_spd, rght_spd} !== 22'd0) begin
            n_err++;
            $display("FAIL stop_final: got l=%0d r=%0d, want 0 0", $signed(lft_spd), $signed(rght_spd));
        end
    endtask

    task automatic test_saturation();
        lft_tgt = 11'(1023); rght_tgt = 11'(-1024); ramp_en = 1'b1;
        for (int i = 0; i < 520; i++) begin
            cyc();
            n_vec++;
            if ({lft_spd, rght_spd, at_tgt} !== {11'(m_l), 11'(m_r), m_at}
                || $signed(lft_spd) > 11'sd1000 || $signed(rght_spd) < -11'sd1000) begin
                n_err++;
                $display("FAIL saturation cyc%0d: got l=%0d r=%0d at=%0b, want l=%0d r=%0d at=%0b",
                         i, $signed(lft_spd), $signed(rght_spd), at_tgt, m_l, m_r, m_at);
            end
        end
        n_vec++;
        if ({lft_spd, rght_spd, at_tgt} !== {11'(1000), 11'(-1000), 1'b1}) begin
            n_err++;
            $display("FAIL saturation_final: got l=%0d r=%0d at=%0b, want 1000 -1000 1",
                     $signed(lft_spd), $signed(rght_spd), at_tgt);
        end
    endtask

    task automatic test_reversal();
        int prev;
        lft_tgt = 11'(1000); rght_tgt = 11'(1000);
        for (int i = 0; i < 1010; i++) cyc();
        n_vec++;
        if ({lft_spd, rght_spd} !== {11'(1000), 11'(1000)}) begin
            n_err++;
            $display("FAIL reversal_setup: got l=%0d r=%0d, want 1000 1000",
                     $signed(lft_spd), $signed(rght_spd));
        end
        lft_tgt = 11'(-1000); rght_tgt = 11'(-1000);
        prev = int'($signed(lft_spd));
        for (int i = 0; i < 1010; i++) begin
            cyc();
            n_vec++;
            if ({lft_spd, rght_spd, at_tgt} !== {11'(m_l), 11'(m_r), m_at}
                || int'($signed(lft_spd)) > prev) begin
                n_err++;
                $display("FAIL reversal cyc%0d: got l=%0d r=%0d at=%0b, want l=%0d r=%0d at=%0b",
                         i, $signed(lft_spd), $signed(rght_spd), at_tgt, m_l, m_r, m_at);
            end
            prev = int'($signed(lft_spd));
        end
    endtask

    task automatic test_brake();
        brake = 1'b1;
        cyc();
        brake = 1'b0;
        lft_tgt = 11'(200); rght_tgt = 11'(200); ramp_en = 1'b1;
        for (int i = 0; i < 110; i++) cyc();
        n_vec++;
        if ({lft_spd, rght_spd} !== {11'(200), 11'(200)}) begin
            n_err++;
            $display("FAIL brake_setup: got l=%0d r=%0d, want 200 200", $signed(lft_spd), $signed(rght_spd));
        end
        brake = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if ({lft_spd, rght_spd, at_tgt} !== 23'd0) begin
                n_err++;
                $display("FAIL brake_hold cyc%0d: got l=%0d r=%0d at=%0b, want 0 0 0",
                         i, $signed(lft_spd), $signed(rght_spd), at_tgt);
            end
        end
        brake = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            n_vec++;
            if ({lft_spd, rght_spd, at_tgt} !== {11'(m_l), 11'(m_r), m_at}) begin
                n_err++;
                $display("FAIL brake_release cyc%0d: got l=%0d r=%0d at=%0b, want l=%0d r=%0d at=%0b",
                         i, $signed(lft_spd), $signed(rght_spd), at_tgt, m_l, m_r, m_at);
            end
        end
    endtask

    task automatic test_async_reset();
        lft_tgt = 11'(500); rght_tgt = 11'(500); ramp_en = 1'b1;
        for (int i = 0; i < 100 && m_l != 96; i++) cyc();
        n_vec++;
        if (lft_spd !== 11'(96)) begin
            n_err++;
            $display("FAIL async_setup: got l=%0d, want 96", $signed(lft_spd));
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({lft_spd, rght_spd, at_tgt} !== 23'd0) begin
            n_err++;
            $display("FAIL async_reset: got l=%0d r=%0d at=%0b, want 0 0 0",
                     $signed(lft_spd), $signed(rght_spd), at_tgt);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ramp_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) ramp_en = 1'b1;
            cyc();
            n_vec++;
            if ({lft_spd, rght_spd, at_tgt} !== {11'(m_l), 11'(m_r), m_at}) begin
                n_err++;
                $display("FAIL async_after cyc%0d: got l=%0d r=%0d at=%0b, want l=%0d r=%0d at=%0b",
                         i, $signed(lft_spd), $signed(rght_spd), at_tgt, m_l, m_r, m_at);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                lft_tgt  = 11'($urandom);
                rght_tgt = 11'($urandom);
            end
            if ($urandom_range(0, 99) == 0) ramp_en = ~ramp_en;
            brake = ($urandom_range(0, 149) == 0);
            cyc();
            n_vec++;
            if ({lft_spd, rght_spd, at_tgt} !== {11'(m_l), 11'(m_r), m_at}) begin
                n_err++;
                $display("FAIL random cyc%0d: got l=%0d r=%0d at=%0b, want l=%0d r=%0d at=%0b",
                         i, $signed(lft_spd), $signed(rght_spd), at_tgt, m_l, m_r, m_at);
            end
        end
        brake = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_basic();
        test_stop();
        test_saturation();
        test_reversal();
        test_brake();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
